// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: forwarding select encoding,
// the per-stage hazard record and a small matching helper.
package hazard_unit_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        FORWARD_NONE = 2'd0,
        FORWARD_WB   = 2'd1,
        FORWARD_MEM  = 2'd2
    } forward_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } hazard_stage_t;

    localparam hazard_stage_t STAGE_BUBBLE = '0;

    // True when the stage will write a non-zero register equal to 'r'.
    function automatic logic stage_writes(input hazard_stage_t s, input logic [REG_W-1:0] r);
        return s.valid & s.regwrite & (s.rd != '0) & (s.rd == r);
    endfunction

endpackage : hazard_unit_pkg

// File: rtl/hazard_unit_fwd_sel.sv
// Forwarding source selection for one EX operand; MEM result is newer than
// WB result and therefore wins when both match.
module fwd_sel
    import hazard_unit_pkg::*;
(
    input  logic [REG_W-1:0] rs_i,
    input  hazard_stage_t    mem_i,
    input  hazard_stage_t    wb_i,
    output forward_t         sel_o
);

    // Priority select: MEM, then WB, else register file.
    always_comb begin
        sel_o = FORWARD_NONE;
        if (stage_writes(mem_i, rs_i)) begin
            sel_o = FORWARD_MEM;
        end else if (stage_writes(wb_i, rs_i)) begin
            sel_o = FORWARD_WB;
        end
    end

endmodule : fwd_sel

// File: rtl/hazard_unit.sv
// Hazard unit for a 5-stage pipeline: tracks EX/MEM/WB register usage,
// produces operand forwarding selects, load-use stalls and redirect flushes.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_branch_taken,
    output forward_t         ex_forward_a,
    output forward_t         ex_forward_b,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             flush_ex
);

    hazard_stage_t ex_q, mem_q, wb_q;
    hazard_stage_t ex_d;
    forward_t      sel_a, sel_b;
    logic          load_use;

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        load_use = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
                   ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
    end

    // Redirect overrides load-use: the flushed ID instruction needs no stall.
    always_comb begin
        flush_id = ex_branch_taken;
        flush_ex = ex_branch_taken | load_use;
        stall_if = ~ex_branch_taken & load_use;
        stall_id = ~ex_branch_taken & load_use;
    end

    // Next EX record: ID fields when valid, bubble when empty or flushed.
    always_comb begin
        ex_d = STAGE_BUBBLE;
        if (id_valid && !flush_ex) begin
            ex_d.valid    = 1'b1;
            ex_d.rs1      = id_rs1;
            ex_d.rs2      = id_rs2;
            ex_d.rd       = id_rd;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
        end
    end

    // Stage record pipeline with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= STAGE_BUBBLE;
            mem_q <= STAGE_BUBBLE;
            wb_q  <= STAGE_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    fwd_sel u_fwd_a (
        .rs_i  (ex_q.rs1),
        .mem_i (mem_q),
        .wb_i  (wb_q),
        .sel_o (sel_a)
    );

    fwd_sel u_fwd_b (
        .rs_i  (ex_q.rs2),
        .mem_i (mem_q),
        .wb_i  (wb_q),
        .sel_o (sel_b)
    );

    // No forwarding for an empty EX slot.
    always_comb begin
        ex_forward_a = ex_q.valid ? sel_a : FORWARD_NONE;
        ex_forward_b = ex_q.valid ? sel_b : FORWARD_NONE;
    end

endmodule : hazard_unit

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// traffic compared against a cycle-history reference model.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_regwrite = 1'b0, id_memread = 1'b0, ex_branch_taken = 1'b0;
    forward_t   ex_forward_a, ex_forward_b;
    logic       stall_if, stall_id, flush_id, flush_ex;

    logic [7:0] dut_vec;
    logic [7:0] exp_vec;
    int         vectors = 0;
    int         errors  = 0;

    hazard_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_regwrite     (id_regwrite),
        .id_memread      (id_memread),
        .ex_branch_taken (ex_branch_taken),
        .ex_forward_a    (ex_forward_a),
        .ex_forward_b    (ex_forward_b),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .flush_id        (flush_id),
        .flush_ex        (flush_ex)
    );

    assign dut_vec = {ex_forward_a, ex_forward_b, stall_if, stall_id, flush_id, flush_ex};

    always #5 clk = ~clk;

    // Reference model: hist[c] is the instruction occupying EX during cycle c.
    // MEM during c is what was in EX at c-1, WB what was in EX at c-2.
    typedef struct {
        bit       valid;
        bit [4:0] rs1, rs2, rd;
        bit       rw, mr;
    } mrec_t;

    localparam int HIST = 4096;
    mrec_t hist [HIST];
    int    cyc     = 0;
    int    rst_cyc = 0;

    function automatic mrec_t rec_at(input int c);
        mrec_t r;
        r = '{default: 0};
        if (c >= 0 && c >= rst_cyc) r = hist[c];
        return r;
    endfunction

    function automatic bit produces(input mrec_t p, input bit [4:0] rs);
        return p.valid && p.rw && p.rd != 0 && p.rd == rs;
    endfunction

    function automatic bit [1:0] m_fwd(input bit use_b);
        mrec_t ex, mem, wb;
        bit [4:0] rs;
        ex = rec_at(cyc);
        if (!ex.valid) return 2'd0;
        rs  = use_b ? ex.rs2 : ex.rs1;
        mem = rec_at(cyc - 1);
        wb  = rec_at(cyc - 2);
        if (produces(mem, rs)) return 2'd2;
        if (produces(wb, rs))  return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit [7:0] model_vec();
        mrec_t ex;
        bit lu, br;
        ex = rec_at(cyc);
        lu = id_valid && ex.valid && ex.mr && ex.rd != 0 &&
             (ex.rd == id_rs1 || ex.rd == id_rs2);
        br = ex_branch_taken;
        return {m_fwd(1'b0), m_fwd(1'b1), !br && lu, !br && lu, br, br || lu};
    endfunction

    // Advance one clock (updating the model with the inputs the DUT sampled),
    // then apply new inputs and compute the expected outputs.
    task automatic drive(input bit rstn, input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                         input bit [4:0] rd, input bit rw, input bit mr, input bit br);
        bit [7:0] e;
        @(posedge clk);
        e = model_vec();
        if (cyc + 1 >= HIST) begin
            $display("FAIL model_bound: cycle %0d required below %0d", cyc + 1, HIST);
            $fatal(1);
        end
        if (!rst_n || e[0] || !id_valid) begin
            hist[cyc + 1] = '{default: 0};
        end else begin
            hist[cyc + 1] = '{1'b1, id_rs1, id_rs2, id_rd, id_regwrite, id_memread};
        end
        if (!rst_n) rst_cyc = cyc + 1;
        cyc++;
        @(negedge clk);
        rst_n = rstn; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_regwrite = rw; id_memread = mr; ex_branch_taken = br;
        #1;
        exp_vec = model_vec();
    endtask

    task automatic nop();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) nop();
    endtask

    task automatic test_reset();
        drive(0, 1, 1, 2, 3, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        if (dut_vec !== exp_vec || dut_vec !== 8'h00) begin
            errors++; $display("FAIL reset_idle: got %b expected %b", dut_vec, exp_vec);
        end
        vectors++;
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        if (dut_vec !== exp_vec || {flush_id, flush_ex, stall_if} !== 3'b110) begin
            errors++; $display("FAIL reset_branch: got %b expected %b", dut_vec, exp_vec);
        end
        vectors++;
        drain();
    endtask

    task automatic test_fwd_mem();
        drive(1, 1, 1, 2, 5, 1, 0, 0);   // add x5,x1,x2
        drive(1, 1, 5, 1, 6, 1, 0, 0);   // add x6,x5,x1
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        if (dut_vec !== exp_vec || ex_forward_a !== FORWARD_MEM || stall_if !== 1'b0) begin
            errors++; $display("FAIL fwd_mem: got %b expected %b", dut_vec, exp_vec);
        end
        vectors++;
        drain();
    endtask

    task automatic test_fwd_wb();
        drive(1, 1, 1, 2, 5, 1, 0, 0);   // add x5
        nop();
        drive(1, 1, 2, 5, 7, 1, 0, 0);   // sub x7,x2,x5
        nop();
        if (dut_vec !== exp_vec || ex_forward_b !== FORWARD_WB || ex_forward_a !== FORWARD_NONE) begin
            errors++; $display("FAIL fwd_wb: got %b expected %b", dut_vec, exp_vec);
        end
        vectors++;
        drain();
    endtask

    task automatic test_load_use();
        drive(1, 1, 3, 0, 8, 1, 1, 0);   // lw x8
        drive(1, 1, 8, 8, 9, 1, 0, 0);   // add x9,x8,x8
        if (dut_vec !== exp_vec || {stall_if, stall_id, flush_ex, flush_id} !== 4'b1110) begin
            errors++; $display("FAIL load_use_stall: got %b expected %b", dut_vec, exp_vec);
        end
        vectors++;
        drive(1, 1, 8, 8, 9, 1, 0, 0);   // held by IF/ID
        if (dut_vec !== exp_vec || {stall_if, stall_id, flush_ex} !== 3'b000) begin
            errors++; $display("FAIL load_use_one_cycle: got %b expected %b", dut_vec, exp_vec);
        end
        vectors++;
        nop();
        if (dut_vec !== exp_vec || ex_forward_a !== FORWARD_WB || ex_forward_b !== FORWARD_WB) begin
            errors++; $display("FAIL load_use_fwd_wb: got %b expected %b", dut_vec, exp_vec);
        end
        vectors++;
        drain();
    endtask

    task automatic test_branch();
        drive(1, 1, 3, 0, 8, 1, 1, 0);   // lw x8
        drive(1, 1, 8, 1, 9, 1, 0, 1);   // dependent + redirect
        if (dut_vec !== exp_vec || {flush_id, flush_ex, stall_if, stall_id} !== 4'b1100) begin
            errors++; $display("FAIL branch_over_stall: got %b expected %b", dut_vec, exp_vec);
        end
        vectors++;
        drain();
    endtask

    task automatic test_x0();
        drive(1, 1, 3, 4, 0, 1, 0, 0);   // write x0
        drive(1, 1, 3, 4, 0, 1, 0, 0);   // write x0
        drive(1, 1, 0, 0, 6, 1, 0, 0);   // reads x0
        nop();
        if (dut_vec !== exp_vec || ex_forward_a !== FORWARD_NONE || ex_forward_b !== FORWARD_NONE) begin
            errors++; $display("FAIL x0_no_fwd: got %b expected %b", dut_vec, exp_vec);
        end
        vectors++;
        drain();
        drive(1, 1, 3, 0, 0, 1, 1, 0);   // lw x0
        drive(1, 1, 0, 0, 6, 1, 0, 0);
        if (dut_vec !== exp_vec || stall_if !== 1'b0 || flush_ex !== 1'b0) begin
            errors++; $display("FAIL x0_no_stall: got %b expected %b", dut_vec, exp_vec);
        end
        vectors++;
        drain();
    endtask

    task automatic test_reset_mid_stall();
        drive(1, 1, 3, 0, 8, 1, 1, 0);   // lw x8
        drive(1, 1, 8, 2, 9, 1, 0, 0);   // stall cycle
        if (dut_vec !== exp_vec || stall_if !== 1'b1) begin
            errors++; $display("FAIL pre_reset_stall: got %b expected %b", dut_vec, exp_vec);
        end
        vectors++;
        drive(0, 1, 8, 2, 9, 1, 0, 0);   // reset while stalled
        drive(1, 1, 8, 2, 9, 1, 0, 0);
        if (dut_vec !== exp_vec || dut_vec !== 8'h00) begin
            errors++; $display("FAIL reset_mid_stall: got %b expected %b", dut_vec, exp_vec);
        end
        vectors++;
        nop();
        if (dut_vec !== exp_vec || dut_vec !== 8'h00) begin
            errors++; $display("FAIL reset_no_survivor: got %b expected %b", dut_vec, exp_vec);
        end
        vectors++;
        drain();
    endtask

    task automatic test_random();
        bit [4:0] rs1 = 0, rs2 = 0, rd = 0;
        bit       v = 0, rw = 0, mr = 0;
        bit       held = 0;
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                v   = ($urandom_range(0, 9) < 8);
                rs1 = 5'($urandom_range(0, 7));
                rs2 = 5'($urandom_range(0, 7));
                rd  = 5'($urandom_range(0, 7));
                rw  = ($urandom_range(0, 9) < 7);
                mr  = ($urandom_range(0, 9) < 3);
            end
            drive(($urandom_range(0, 49) != 0), v, rs1, rs2, rd, rw, mr,
                  ($urandom_range(0, 9) == 0));
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL random_%0d: got %b expected %b", i, dut_vec, exp_vec);
            end
            vectors++;
            held = exp_vec[3];
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_fwd_mem();
        test_fwd_wb();
        test_load_use();
        test_branch();
        test_x0();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t required completion earlier", $time);
        $fatal(1);
    end

endmodule : tb_hazard_unit
